// File: rtl/tx_resp_arbiter.sv
// Arbitrates register-read and ALU responses onto a byte-wide TX FIFO write port.
// Optional sticky overflow flag for dropped pulses: define RESP_OVF_EN.
module tx_resp_arbiter #(
   parameter int data_width = 8,
   parameter int width      = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [data_width-1:0] RdData,
   input  logic                  RdData_Valid,
   input  logic [width-1:0]      ALU_OUT,
   input  logic                  OUT_VALID,
   input  logic                  wfull,
`ifdef RESP_OVF_EN
   input  logic                  OVF_CLR,
   output logic                  OVF,
`endif
   output logic [data_width-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  RD_BUSY,
   output logic                  ALU_BUSY
);

   localparam logic [1:0] IDLE        = 2'd0;
   localparam logic [1:0] SEND_RD     = 2'd1;
   localparam logic [1:0] SEND_ALU_LO = 2'd2;
   localparam logic [1:0] SEND_ALU_HI = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [data_width-1:0] r_rd_hold;
   logic                  r_rd_vld;
   logic [width-1:0]      r_alu_hold;
   logic                  r_alu_vld;
   logic                  r_last_alu;
   logic                  w_grant_rd;
   logic                  w_grant_alu;
   logic                  w_rd_rel;
   logic                  w_alu_rel;
   logic                  w_rd_cap;
   logic                  w_alu_cap;

   assign TX_D_VLD = (r_state != IDLE) && !wfull;
   assign RD_BUSY  = r_rd_vld;
   assign ALU_BUSY = r_alu_vld;

   assign w_rd_rel  = TX_D_VLD && (r_state == SEND_RD);
   assign w_alu_rel = TX_D_VLD && (r_state == SEND_ALU_HI);
   // A release frees the slot on the same edge, so a coincident pulse is taken.
   assign w_rd_cap  = RdData_Valid && (!r_rd_vld || w_rd_rel);
   assign w_alu_cap = OUT_VALID && (!r_alu_vld || w_alu_rel);

   always_comb begin
      w_next_state = r_state;
      w_grant_rd   = 1'b0;
      w_grant_alu  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_rd_vld && r_alu_vld) begin
               w_grant_rd  = r_last_alu;
               w_grant_alu = !r_last_alu;
            end else begin
               w_grant_rd  = r_rd_vld;
               w_grant_alu = r_alu_vld;
            end
            if (w_grant_rd) begin
               w_next_state = SEND_RD;
            end else if (w_grant_alu) begin
               w_next_state = SEND_ALU_LO;
            end
         end
         SEND_RD:     if (TX_D_VLD) w_next_state = IDLE;
         SEND_ALU_LO: if (TX_D_VLD) w_next_state = SEND_ALU_HI;
         SEND_ALU_HI: if (TX_D_VLD) w_next_state = IDLE;
         default:     w_next_state = IDLE;
      endcase
   end

   always_comb begin
      TX_P_DATA = '0;
      case (r_state)
         SEND_RD:     TX_P_DATA = r_rd_hold;
         SEND_ALU_LO: TX_P_DATA = r_alu_hold[data_width-1:0];
         SEND_ALU_HI: TX_P_DATA = r_alu_hold[width-1:data_width];
         default:     TX_P_DATA = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= IDLE;
         r_last_alu <= 1'b1;
      end else begin
         r_state <= w_next_state;
         if (w_grant_rd) begin
            r_last_alu <= 1'b0;
         end else if (w_grant_alu) begin
            r_last_alu <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_rd_hold <= '0;
         r_rd_vld  <= 1'b0;
      end else if (w_rd_cap) begin
         r_rd_hold <= RdData;
         r_rd_vld  <= 1'b1;
      end else if (w_rd_rel) begin
         r_rd_vld <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_alu_hold <= '0;
         r_alu_vld  <= 1'b0;
      end else if (w_alu_cap) begin
         r_alu_hold <= ALU_OUT;
         r_alu_vld  <= 1'b1;
      end else if (w_alu_rel) begin
         r_alu_vld <= 1'b0;
      end
   end

`ifdef RESP_OVF_EN
   logic r_ovf;
   logic w_drop;

   assign w_drop = (RdData_Valid && !w_rd_cap) || (OUT_VALID && !w_alu_cap);
   assign OVF    = r_ovf;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (OVF_CLR) begin
         r_ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Randomized + directed bench for tx_resp_arbiter against a message-queue reference model.
module tb_tx_resp_arbiter;

   logic        CLK;
   logic        RST;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic [15:0] ALU_OUT;
   logic        OUT_VALID;
   logic        wfull;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        RD_BUSY;
   logic        ALU_BUSY;
`ifdef RESP_OVF_EN
   logic        OVF_CLR;
   logic        OVF;
`endif

   tx_resp_arbiter #(
      .data_width(8),
      .width     (16)
   ) u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .RdData      (RdData),
      .RdData_Valid(RdData_Valid),
      .ALU_OUT     (ALU_OUT),
      .OUT_VALID   (OUT_VALID),
      .wfull       (wfull),
`ifdef RESP_OVF_EN
      .OVF_CLR     (OVF_CLR),
      .OVF         (OVF),
`endif
      .TX_P_DATA   (TX_P_DATA),
      .TX_D_VLD    (TX_D_VLD),
      .RD_BUSY     (RD_BUSY),
      .ALU_BUSY    (ALU_BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending requests plus the bytes of the message in flight.
   logic [7:0]  m_q[$];
   int          m_src;
   logic        m_rd_v;
   logic [7:0]  m_rd_d;
   logic        m_alu_v;
   logic [15:0] m_alu_d;
   logic        m_lg_alu;
   logic        m_ovf;
   logic [7:0]  sent[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_src    = 0;
      m_rd_v   = 1'b0;
      m_rd_d   = 8'h00;
      m_alu_v  = 1'b0;
      m_alu_d  = 16'h0000;
      m_lg_alu = 1'b1;
      m_ovf    = 1'b0;
   endtask

   task automatic model_edge(input logic rdv, input logic [7:0] rdd, input logic aluv,
                             input logic [15:0] alud, input logic wf, input logic clr);
      logic drop;
      logic pick_rd;
      drop = 1'b0;
      if (m_q.size() != 0) begin
         if (!wf) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               if (m_src == 1) m_rd_v = 1'b0;
               else            m_alu_v = 1'b0;
            end
         end
      end else if (m_rd_v || m_alu_v) begin
         pick_rd = m_rd_v && (!m_alu_v || m_lg_alu);
         if (pick_rd) begin
            m_q.push_back(m_rd_d);
            m_src    = 1;
            m_lg_alu = 1'b0;
         end else begin
            m_q.push_back(m_alu_d[7:0]);
            m_q.push_back(m_alu_d[15:8]);
            m_src    = 2;
            m_lg_alu = 1'b1;
         end
      end
      if (rdv) begin
         if (!m_rd_v) begin
            m_rd_v = 1'b1;
            m_rd_d = rdd;
         end else drop = 1'b1;
      end
      if (aluv) begin
         if (!m_alu_v) begin
            m_alu_v = 1'b1;
            m_alu_d = alud;
         end else drop = 1'b1;
      end
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   // One clock: drive, check outputs at the falling edge, advance model at the rising edge.
   task automatic step(input logic rdv, input logic [7:0] rdd, input logic aluv,
                       input logic [15:0] alud, input logic wf, input logic clr);
      logic       e_vld;
      logic [7:0] e_data;
      RdData_Valid = rdv;
      RdData       = rdd;
      OUT_VALID    = aluv;
      ALU_OUT      = alud;
      wfull        = wf;
`ifdef RESP_OVF_EN
      OVF_CLR      = clr;
`endif
      @(negedge CLK);
      e_vld  = (m_q.size() != 0) && !wf;
      e_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
      check("tx_vld", {31'd0, TX_D_VLD}, {31'd0, e_vld});
      check("tx_data", {24'd0, TX_P_DATA}, {24'd0, e_data});
      check("rd_busy", {31'd0, RD_BUSY}, {31'd0, m_rd_v});
      check("alu_busy", {31'd0, ALU_BUSY}, {31'd0, m_alu_v});
`ifdef RESP_OVF_EN
      check("ovf", {31'd0, OVF}, {31'd0, m_ovf});
`endif
      if (TX_D_VLD) sent.push_back(TX_P_DATA);
      @(posedge CLK);
      model_edge(rdv, rdd, aluv, alud, wf, clr);
      #1;
   endtask

   task automatic idle(input logic wf);
      step(1'b0, 8'h00, 1'b0, 16'h0000, wf, 1'b0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_vld"}, {31'd0, TX_D_VLD}, 32'd0);
      check({tag, "_data"}, {24'd0, TX_P_DATA}, 32'd0);
      check({tag, "_rdb"}, {31'd0, RD_BUSY}, 32'd0);
      check({tag, "_alub"}, {31'd0, ALU_BUSY}, 32'd0);
`ifdef RESP_OVF_EN
      check({tag, "_ovf"}, {31'd0, OVF}, 32'd0);
`endif
   endtask

   task automatic do_reset();
      RST          = 1'b0;
      RdData_Valid = 1'b0;
      RdData       = 8'h00;
      OUT_VALID    = 1'b0;
      ALU_OUT      = 16'h0000;
      wfull        = 1'b0;
`ifdef RESP_OVF_EN
      OVF_CLR      = 1'b0;
`endif
      model_reset();
      #1;
      check_zero_outputs("rst_async");
      @(posedge CLK);
      @(negedge CLK);
      check_zero_outputs("rst_hold");
      RST = 1'b1;
      @(posedge CLK);
      model_edge(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
   endtask

   task automatic check_log(input string tag, input int n, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2);
      logic [7:0]  e;
      logic [31:0] got;
      check({tag, "_count"}, sent.size(), n);
      for (int i = 0; i < n; i++) begin
         e   = (i == 0) ? e0 : ((i == 1) ? e1 : e2);
         got = (i < sent.size()) ? {24'd0, sent[i]} : 32'hFFFF_FFFF;
         check({tag, "_byte"}, got, {24'd0, e});
      end
      sent.delete();
   endtask

   initial begin
      do_reset();

      // Tie straight after reset: read wins, then the full ALU message.
      sent.delete();
      step(1'b1, 8'hA1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      repeat (8) idle(1'b0);
      check_log("tie1", 3, 8'hA1, 8'hEF, 8'hBE);

      // A lone read makes read the last grant, so the next tie goes to ALU.
      step(1'b1, 8'h33, 1'b0, 16'h0000, 1'b0, 1'b0);
      repeat (4) idle(1'b0);
      check_log("lone", 1, 8'h33, 8'h00, 8'h00);
      step(1'b1, 8'h44, 1'b1, 16'h5566, 1'b0, 1'b0);
      repeat (8) idle(1'b0);
      check_log("tie2", 3, 8'h66, 8'h55, 8'h44);

      // Latency: strobe two cycles after the pulse.
      step(1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0, 1'b0);
      idle(1'b0);
      check("lat_n1", sent.size(), 0);
      idle(1'b0);
      repeat (3) idle(1'b0);
      check_log("lat", 1, 8'h5A, 8'h00, 8'h00);

      step(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0);
      repeat (6) idle(1'b0);
      check_log("alu", 2, 8'h34, 8'h12, 8'h00);

      // Back-pressure while the HI byte is presented.
      step(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      repeat (5) idle(1'b1);
      repeat (4) idle(1'b0);
      check_log("full_hi", 2, 8'h34, 8'h12, 8'h00);

      // Pulse coinciding with release is captured.
      step(1'b1, 8'h77, 1'b0, 16'h0000, 1'b0, 1'b0);
      idle(1'b0);
      step(1'b1, 8'h88, 1'b0, 16'h0000, 1'b0, 1'b0);
      repeat (5) idle(1'b0);
      check_log("rel_cap", 2, 8'h77, 8'h88, 8'h00);

      // Second read while the first is stuck behind a full FIFO is dropped.
      step(1'b1, 8'h11, 1'b0, 16'h0000, 1'b1, 1'b0);
      repeat (3) idle(1'b1);
      step(1'b1, 8'h22, 1'b0, 16'h0000, 1'b1, 1'b0);
      repeat (3) idle(1'b1);
`ifdef RESP_OVF_EN
      check("ovf_set", {31'd0, OVF}, 32'd1);
`endif
      repeat (4) idle(1'b0);
      check_log("drop", 1, 8'h11, 8'h00, 8'h00);
`ifdef RESP_OVF_EN
      check("ovf_sticky", {31'd0, OVF}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
      check("ovf_clr", {31'd0, OVF}, 32'd0);
`endif

      // Reset between LO and HI bytes discards the HI byte.
      step(1'b0, 8'h00, 1'b1, 16'hCAFE, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      do_reset();
      repeat (6) idle(1'b0);
      check_log("rst_mid", 1, 8'hFE, 8'h00, 8'h00);

      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
              16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/tx_resp_arbiter.md
TX_RESP_ARBITER -- requirements
Module: tx_resp_arbiter

Interface
REQ-001 Parameter data_width, default 8, SHALL set the TX byte width and the register read-data width.
REQ-002 Parameter width, default 16, SHALL set the ALU result width and SHALL equal 2*data_width.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 RdData  input  data_width  SHALL carry the register-file read data.
REQ-006 RdData_Valid  input  1  SHALL be a one-cycle pulse qualifying RdData.
REQ-007 ALU_OUT  input  width  SHALL carry the ALU result.
REQ-008 OUT_VALID  input  1  SHALL be a one-cycle pulse qualifying ALU_OUT.
REQ-009 wfull  input  1  SHALL be the TX FIFO full flag.
REQ-010 TX_P_DATA  output  data_width  SHALL carry the byte presented to the TX FIFO write port.
REQ-011 TX_D_VLD  output  1  SHALL be the FIFO write strobe; the FIFO takes one byte per high cycle.
REQ-012 RD_BUSY  output  1  SHALL be high while the read holding register is occupied.
REQ-013 ALU_BUSY  output  1  SHALL be high while the ALU holding register is occupied.

Function
REQ-014 A RdData_Valid pulse SHALL capture RdData into an 8-bit read holding register and set its valid bit on the same edge.
REQ-015 An OUT_VALID pulse SHALL capture ALU_OUT into a 16-bit ALU holding register and set its valid bit on the same edge.
REQ-016 The FSM SHALL have exactly four states: IDLE, SEND_RD, SEND_ALU_LO and SEND_ALU_HI.
REQ-017 In IDLE with only one holding register valid, the FSM SHALL move to that requester's send state (SEND_RD or SEND_ALU_LO) on the next edge.
REQ-018 In IDLE with both holding registers valid, the FSM SHALL grant round-robin against a last_grant bit; last_grant SHALL update on each grant.
REQ-019 TX_D_VLD SHALL be combinational: high iff state is SEND_* and wfull=0.
REQ-020 TX_P_DATA SHALL be rd_hold in SEND_RD, alu_hold[7:0] in SEND_ALU_LO, alu_hold[15:8] in SEND_ALU_HI, and 0 otherwise.
REQ-021 A byte SHALL be accepted on each edge where TX_D_VLD=1; the FSM SHALL hold its state while wfull=1.
REQ-022 On acceptance the FSM SHALL move SEND_RD->IDLE, SEND_ALU_LO->SEND_ALU_HI and SEND_ALU_HI->IDLE.
REQ-023 The read valid bit SHALL clear on acceptance in SEND_RD; the ALU valid bit SHALL clear on acceptance in SEND_ALU_HI.
REQ-024 An ALU message SHALL be atomic: no read byte SHALL be inserted between its LO and HI bytes.
REQ-025 Latency: a pulse at edge n with an empty holding register, IDLE state and wfull=0 SHALL give TX_D_VLD=1 during cycle n+2.
REQ-026 A pulse arriving on the same edge its holding register is released SHALL be captured, and the register SHALL stay valid.
REQ-027 A pulse arriving while its holding register is occupied and not being released SHALL be dropped; the held data SHALL remain unchanged.

Reset
REQ-028 RST low SHALL asynchronously set state to IDLE, clear both valid bits and holding registers, and set last_grant to ALU so that the read requester wins the first tie.
REQ-029 During reset, TX_D_VLD, RD_BUSY, ALU_BUSY and TX_P_DATA SHALL all be 0.
REQ-030 Reset mid-message SHALL discard any partially sent ALU result; no HI byte SHALL follow after reset release.

Configuration
REQ-031 With macro RESP_OVF_EN defined, the block SHALL add input OVF_CLR (1 bit) and output OVF (1 bit, sticky).
REQ-032 With RESP_OVF_EN defined, OVF SHALL set on any dropped pulse (REQ-027) and SHALL clear on OVF_CLR=1 or on reset; a drop takes priority over OVF_CLR in the same cycle.
REQ-033 Without RESP_OVF_EN, OVF and OVF_CLR SHALL be absent and drops SHALL be silent.

Verification
REQ-034 The bench SHALL pulse RdData_Valid with RdData=0x5A, wfull=0 -> TX_D_VLD one cycle, TX_P_DATA=0x5A, two cycles after the pulse.
REQ-035 The bench SHALL pulse OUT_VALID with ALU_OUT=0x1234 -> bytes 0x34 then 0x12 on consecutive cycles.
REQ-036 The bench SHALL pulse both requesters in the same cycle (0xA1, 0xBEEF) right after reset -> byte order 0xA1, 0xEF, 0xBE; a second tie SHALL send the ALU message first.
REQ-037 The bench SHALL hold wfull=1 for 5 cycles while in SEND_ALU_HI -> TX_D_VLD=0 throughout, then 0x12 is sent once after wfull falls.
REQ-038 The bench SHALL hold wfull=1, pulse RdData_Valid twice (0x11, then 0x22) -> only 0x11 is sent and, with RESP_OVF_EN defined, OVF=1 until OVF_CLR.
REQ-039 The bench SHALL assert RST between the LO and HI bytes of ALU_OUT=0xCAFE -> no 0xCA byte is sent and all outputs are 0.
